// File: rtl/mips_reg_file_8x32_pkg.sv
// Shared MIPS datapath constants and the register-file write decoder.
package mips_reg_file_8x32_pkg;

    localparam int REG_COUNT   = 8;
    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 3;
    localparam int R0_IDX      = 0;

    // One-hot write enable for the addressed register; all-zero when not writing.
    function automatic logic [REG_COUNT-1:0] dec3to8(
        input logic                   en,
        input logic [MIPS_ADDR_W-1:0] addr
    );
        logic [REG_COUNT-1:0] onehot;
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/mips_reg_file_8x32_mux.sv
// Word-wide 4:1 and 2:1 mux primitives; each output bit is an independent selection.
module mips_mux4 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    input  logic [1:0]   sel_i,
    output logic [W-1:0] y_o
);

    // Pure combinational selection, no storage.
    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0: y_o = d0_i;
            2'd1: y_o = d1_i;
            2'd2: y_o = d2_i;
            2'd3: y_o = d3_i;
            default: y_o = d0_i;
        endcase
    end

endmodule

module mips_mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mips_reg_file_8x32_reg_en_w.sv
// DATA_W-bit register with synchronous load enable and asynchronous active-low clear.
module reg_en_w #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    assign data_d = en_i ? d_i : data_q;

    // Clear immediately on reset, otherwise load when enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mips_reg_file_8x32.sv
// 8 x DATA_W MIPS register file: one write port, two combinational read ports,
// r0 tied to zero, and a wrapping counter of accepted writes.
module mips_reg_file_8x32
    import mips_reg_file_8x32_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [7:0]        wr_cnt
);

    logic [REG_COUNT-1:0] wen;
    logic [DATA_W-1:0]    regs [REG_COUNT];
    logic [DATA_W-1:0]    lo1, hi1, lo2, hi2;
    logic                 wr_acc;
    logic [7:0]           wr_cnt_q;
    logic [7:0]           wr_cnt_d;

    // Decode the write address; the r0 enable is forced off so its writes vanish.
    always_comb begin
        wen         = dec3to8(we, wa);
        wen[R0_IDX] = 1'b0;
    end

    assign regs[R0_IDX] = '0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        reg_en_w #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk_i (clk),
            .rst_ni(rst_n),
            .en_i  (wen[i]),
            .d_i   (wd),
            .q_o   (regs[i])
        );
    end

    // Read port 1: low/high 4:1 trees on ra1[1:0], final 2:1 on ra1[2].
    mips_mux4 #(.W(DATA_W)) u_rd1_lo (
        .d0_i(regs[0]), .d1_i(regs[1]), .d2_i(regs[2]), .d3_i(regs[3]),
        .sel_i(ra1[1:0]), .y_o(lo1)
    );
    mips_mux4 #(.W(DATA_W)) u_rd1_hi (
        .d0_i(regs[4]), .d1_i(regs[5]), .d2_i(regs[6]), .d3_i(regs[7]),
        .sel_i(ra1[1:0]), .y_o(hi1)
    );
    mips_mux2 #(.W(DATA_W)) u_rd1_top (
        .d0_i(lo1), .d1_i(hi1), .sel_i(ra1[2]), .y_o(rd1)
    );

    // Read port 2: same tree structure driven by ra2.
    mips_mux4 #(.W(DATA_W)) u_rd2_lo (
        .d0_i(regs[0]), .d1_i(regs[1]), .d2_i(regs[2]), .d3_i(regs[3]),
        .sel_i(ra2[1:0]), .y_o(lo2)
    );
    mips_mux4 #(.W(DATA_W)) u_rd2_hi (
        .d0_i(regs[4]), .d1_i(regs[5]), .d2_i(regs[6]), .d3_i(regs[7]),
        .sel_i(ra2[1:0]), .y_o(hi2)
    );
    mips_mux2 #(.W(DATA_W)) u_rd2_top (
        .d0_i(lo2), .d1_i(hi2), .sel_i(ra2[2]), .y_o(rd2)
    );

    // Any surviving enable is an accepted write.
    assign wr_acc   = |wen;
    assign wr_cnt_d = wr_acc ? (wr_cnt_q + 8'd1) : wr_cnt_q;

    // Accepted-write counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mips_reg_file_8x32.sv
// Randomized and directed scoreboard bench for mips_reg_file_8x32.
module tb_mips_reg_file_8x32;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [7:0]  wr_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: plain array of register contents and an integer write count.
    int unsigned mdl_reg [8];
    int unsigned mdl_cnt;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [7:0]  ec;
    } exp_t;

    exp_t sb [$];

    mips_reg_file_8x32 #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Monitor: outputs are settled 2 time units after each drive point.
    always @(negedge clk) begin
        exp_t t;
        #2;
        if (sb.size() > 0) begin
            t = sb.pop_front();
            checks++;
            if (rd1 !== t.e1) begin
                errors++;
                $display("FAIL rd1 cyc=%0d ra1=%0d actual=%h required=%h", t.cyc, t.a1, rd1, t.e1);
            end
            checks++;
            if (rd2 !== t.e2) begin
                errors++;
                $display("FAIL rd2 cyc=%0d ra2=%0d actual=%h required=%h", t.cyc, t.a2, rd2, t.e2);
            end
            checks++;
            if (wr_cnt !== t.ec) begin
                errors++;
                $display("FAIL wr_cnt cyc=%0d actual=%0d required=%0d", t.cyc, wr_cnt, t.ec);
            end
        end
    end

    // One cycle: drive at negedge, predict pre-edge reads, then apply the write rule at posedge.
    task automatic step(input logic r, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [2:0] q1, input logic [2:0] q2);
        exp_t t;
        @(negedge clk);
        rst_n = r; we = w; wa = a; wd = d; ra1 = q1; ra2 = q2;
        cyc++;
        if (!r) begin
            for (int k = 0; k < 8; k++) mdl_reg[k] = 0;
            mdl_cnt = 0;
        end
        t.cyc = cyc;
        t.a1  = q1;
        t.a2  = q2;
        t.e1  = mdl_reg[q1];
        t.e2  = mdl_reg[q2];
        t.ec  = 8'(mdl_cnt % 256);
        sb.push_back(t);
        @(posedge clk);
        if (r && w && a != 3'd0) begin
            mdl_reg[a] = d;
            mdl_cnt    = (mdl_cnt + 1) % 256;
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mdl_reg[k] = 0;
        mdl_cnt = 0;
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

        // Reset: every address reads zero, even with we asserted.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 32'hCAFE0000 + i, 3'(i), 3'(7 - i));

        // Basic write then readback.
        step(1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 3'd3, 3'd0);
        step(1'b1, 1'b0, 3'd0, 32'h0,        3'd3, 3'd3);

        // r0 protection.
        step(1'b1, 1'b1, 3'd0, 32'hFFFFFFFF, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 32'h0,        3'd0, 3'd3);

        // Same-cycle read/write: old value before the edge, new after.
        step(1'b1, 1'b1, 3'd5, 32'h11111111, 3'd0, 3'd0);
        step(1'b1, 1'b1, 3'd5, 32'h22222222, 3'd5, 3'd5);
        step(1'b1, 1'b0, 3'd5, 32'h33333333, 3'd5, 3'd5);

        // Dual read and hold for 4 edges.
        step(1'b1, 1'b1, 3'd2, 32'hA5A5A5A5, 3'd0, 3'd0);
        step(1'b1, 1'b1, 3'd7, 32'h0000FFFF, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'd2, 32'h5A5A5A5A, 3'd2, 3'd7);
        step(1'b1, 1'b0, 3'd0, 32'h0, 3'd2, 3'd2);

        // Async reset mid-operation with we held high.
        step(1'b1, 1'b1, 3'd4, 32'h12345678, 3'd4, 3'd4);
        step(1'b1, 1'b0, 3'd4, 32'h0,        3'd4, 3'd4);
        step(1'b0, 1'b1, 3'd4, 32'h87654321, 3'd4, 3'd4);
        step(1'b0, 1'b1, 3'd4, 32'h87654321, 3'd4, 3'd1);
        // Release with we=1: write is taken at the first following edge.
        step(1'b1, 1'b1, 3'd6, 32'h0BADF00D, 3'd4, 3'd6);
        step(1'b1, 1'b0, 3'd0, 32'h0,        3'd6, 3'd4);

        // Counter wrap: reset, then 256 accepted writes.
        step(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 3'($urandom_range(1, 7)), $urandom, 3'($urandom), 3'($urandom));
        step(1'b1, 1'b0, 3'd0, 32'h0, 3'd1, 3'd7);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 63) != 0), 1'($urandom), 3'($urandom), $urandom,
                 3'($urandom), 3'($urandom));
        end

        @(negedge clk);
        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending entries actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_reg_file_8x32.md
MIPS_REG_FILE_8X32 -- requirements
Module: mips_reg_file_8x32

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register-address width (8 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port we  input  1  write enable for the write port.
REQ-006 SHALL have port wa  input  ADDR_W  write address.
REQ-007 SHALL have port wd  input  DATA_W  write data.
REQ-008 SHALL have port ra1  input  ADDR_W  read address, port 1 (rs).
REQ-009 SHALL have port ra2  input  ADDR_W  read address, port 2 (rt).
REQ-010 SHALL have port rd1  output  DATA_W  read data, port 1.
REQ-011 SHALL have port rd2  output  DATA_W  read data, port 2.
REQ-012 SHALL have port wr_cnt  output  8  count of accepted writes to r1..r7 since reset, wrapping at 8 bits.

Function
REQ-013 SHALL hold 8 registers r0..r7, each DATA_W bits.
REQ-014 SHALL keep r0 hardwired to zero: writes to wa=0 are discarded and do not increment wr_cnt.
REQ-015 SHALL write wd into register wa at the rising clk edge when we=1 and wa!=0.
REQ-016 SHALL leave every register unchanged at an edge when we=0.
REQ-017 SHALL drive rd1/rd2 combinationally from the register selected by ra1/ra2, with zero cycles of latency from an address change.
REQ-018 SHALL build each read port as a per-bit 8:1 selection tree indexed by the 3-bit address (two 4:1 stages feeding one 2:1 stage).
REQ-019 SHALL, when ra equals wa with we=1 in the same cycle, return the old register content until the edge and the new content after it (no write-through bypass).
REQ-020 SHALL allow ra1=ra2, with both ports returning the same value.
REQ-021 SHALL decode wa with a 3-to-8 decoder ANDed with we, giving exactly one or zero register enables per cycle.
REQ-022 SHALL increment wr_cnt by 1 on each accepted write (REQ-015), wrapping 255->0.
REQ-023 SHALL treat X/Z on we as no write in simulation checks; implementation is not required to filter it.

Reset
REQ-024 SHALL clear r1..r7 and wr_cnt to 0 immediately when rst_n falls, independent of clk.
REQ-025 SHALL, while rst_n=0, drive rd1=rd2=0 for every address and ignore we.
REQ-026 SHALL, on rst_n deassertion, accept a write at the first rising edge that follows with rst_n=1.
REQ-027 SHALL let a reset asserted mid-write win: no register takes wd at an edge where rst_n=0.

Structure
REQ-028 SHALL place REG_COUNT=8, DATA_W=32, ADDR_W=3 and the R0 index constant in the shared MIPS package/header used by the datapath.
REQ-029 SHALL use one sub-module, reg_en_w (DATA_W flip-flops with synchronous enable and async active-low clear), instantiated 7 times for r1..r7.
REQ-030 SHALL reuse the existing 4:1 and 2:1 mux primitives for the read trees; the decoder and counter are local.

Verification
REQ-031 SHALL cover reset: pulse rst_n low, ra1=0..7 -> rd1=0 for all, wr_cnt=0.
REQ-032 SHALL cover basic write: we=1, wa=3, wd=0xDEADBEEF, one edge; then ra1=3 -> rd1=0xDEADBEEF and wr_cnt=1.
REQ-033 SHALL cover r0 protection: we=1, wa=0, wd=0xFFFFFFFF, one edge -> rd1(ra1=0)=0 and wr_cnt unchanged.
REQ-034 SHALL cover same-cycle read/write: r5=0x11111111, then we=1, wa=5, wd=0x22222222, ra2=5 -> rd2=0x11111111 before the edge and 0x22222222 after it.
REQ-035 SHALL cover dual read and hold: r2=0xA5A5A5A5, r7=0x0000FFFF, we=0 for 4 edges, ra1=2, ra2=7 -> rd1=0xA5A5A5A5, rd2=0x0000FFFF, unchanged.
REQ-036 SHALL cover async reset mid-operation: write r4=0x12345678, assert rst_n between edges with we=1 -> r4 reads 0 immediately, 0 after release, and wr_cnt=0; 256 accepted writes -> wr_cnt wraps to 0.
